// File: rtl/cfa_window_stream.sv
// Streaming FilterSize x FilterSize window generator for the CFA pipeline.
// Pixels arrive in raster order. FilterSize-1 circular line buffers supply
// the older rows, d_in_i supplies the newest row, and a per-channel shift
// window collects the last FilterSize columns. A window is emitted only when
// it lies fully inside the image. The window register is also the output.
module cfa_window_stream #(
   parameter int DataBitWidth = 8,
   parameter int FilterSize   = 3,
   parameter int NoOfChannels = 3,
   parameter int MaxLineWidth = 640,
   parameter int ColBitWidth  = 10,
   parameter int RowBitWidth  = 10
) (
   input  logic                                                     clk_i,
   input  logic                                                     rst_ni,
   input  logic                                                     en_i,
   input  logic [ColBitWidth-1:0]                                   line_width_i,
   input  logic [RowBitWidth-1:0]                                   frame_height_i,
   input  logic                                                     in_valid_i,
   output logic                                                     in_ready_o,
   input  logic                                                     in_sof_i,
   input  logic [NoOfChannels*DataBitWidth-1:0]                     d_in_i,
   output logic                                                     win_valid_o,
   input  logic                                                     out_ready_i,
   output logic [DataBitWidth*FilterSize*FilterSize*NoOfChannels-1:0] window_data_o,
   output logic [RowBitWidth-1:0]                                   win_row_o,
   output logic [ColBitWidth-1:0]                                   win_col_o,
   output logic [1:0]                                               cfa_phase_o,
   output logic                                                     frame_done_o,
   output logic                                                     cfg_err_o
);

   localparam int DW   = DataBitWidth;
   localparam int FS   = FilterSize;
   localparam int NCH  = NoOfChannels;
   localparam int CW   = ColBitWidth;
   localparam int RW   = RowBitWidth;
   localparam int PW   = NCH * DW;
   localparam int NLB  = FS - 1;
   localparam int HALF = (FS - 1) / 2;
   localparam int AW   = $clog2(MaxLineWidth);

   localparam logic [CW-1:0] LW_MIN   = CW'(FS);
   localparam logic [CW-1:0] LW_MAX   = CW'(MaxLineWidth);
   localparam logic [CW-1:0] COL_EDGE = CW'(FS - 1);
   localparam logic [CW-1:0] COL_HALF = CW'(HALF);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] FH_MIN   = RW'(FS);
   localparam logic [RW-1:0] ROW_EDGE = RW'(FS - 1);
   localparam logic [RW-1:0] ROW_HALF = RW'(HALF);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);

   // Packed so that element [k][i][j] sits at ((k*FS+i)*FS+j)*DW.
   typedef logic [NCH-1:0][FS-1:0][FS-1:0][DW-1:0] win_t;

   logic [RW-1:0]  row_q, row_d;
   logic [CW-1:0]  col_q, col_d;
   logic [CW-1:0]  lw_q, lw_d;
   logic [RW-1:0]  fh_q, fh_d;
   logic           err_q, err_d;
   logic [NLB-1:0] wsel_q, wsel_d;
   win_t           win_q, win_d;
   logic           wv_q, wv_d;
   logic [RW-1:0]  wrow_q, wrow_d;
   logic [CW-1:0]  wcol_q, wcol_d;
   logic           fd_q, fd_d;

   logic [PW-1:0]  lbuf_q [NLB][MaxLineWidth];
   logic [NLB-1:0][PW-1:0] rd;
   logic [FS-1:0][PW-1:0]  tap;

   logic           accept, wr_en, is_start, cfg_bad, col_last, row_last;
   logic [RW-1:0]  row_eff, fh_eff;
   logic [CW-1:0]  col_eff, lw_eff;
   logic [AW-1:0]  addr;

   // A held window blocks input; reset and a config error block it outright.
   assign in_ready_o = rst_ni & en_i & ~err_q & (~wv_q | out_ready_i);
   assign accept     = in_valid_i & in_ready_o;

   // Effective position of the incoming pixel: in_sof forces the frame origin.
   always_comb begin
      row_eff  = in_sof_i ? '0 : row_q;
      col_eff  = in_sof_i ? '0 : col_q;
      is_start = (row_eff == '0) && (col_eff == '0);
      lw_eff   = is_start ? line_width_i   : lw_q;
      fh_eff   = is_start ? frame_height_i : fh_q;
      cfg_bad  = (line_width_i < LW_MIN) || (line_width_i > LW_MAX) ||
                 (frame_height_i < FH_MIN);
      col_last = (col_eff == lw_eff - COL_ONE);
      row_last = (row_eff == fh_eff - ROW_ONE);
      addr     = AW'(col_eff);
   end

   // Line-buffer taps ordered oldest first; the buffer being overwritten
   // holds the oldest line, the one after it in rotation order the next.
   always_comb begin
      for (int b = 0; b < NLB; b++) begin
         rd[b] = lbuf_q[b][addr];
      end
      tap = '0;
      for (int i = 0; i < NLB; i++) begin
         for (int b = 0; b < NLB; b++) begin
            if (wsel_q[(b - i + NLB) % NLB]) begin
               tap[i] = tap[i] | rd[b];
            end
         end
      end
      tap[FS-1] = d_in_i;
   end

   // Next state: output clear on handshake, then accept/shift/count.
   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      lw_d   = lw_q;
      fh_d   = fh_q;
      err_d  = err_q;
      wsel_d = wsel_q;
      win_d  = win_q;
      wv_d   = wv_q;
      wrow_d = wrow_q;
      wcol_d = wcol_q;
      fd_d   = fd_q;
      wr_en  = 1'b0;
      if (en_i && wv_q && out_ready_i) begin
         wv_d = 1'b0;
         fd_d = 1'b0;
      end
      if (accept) begin
         if (is_start) begin
            lw_d = line_width_i;
            fh_d = frame_height_i;
         end
         if (is_start && cfg_bad) begin
            err_d = 1'b1;
            row_d = '0;
            col_d = '0;
         end else begin
            wr_en = 1'b1;
            for (int k = 0; k < NCH; k++) begin
               for (int i = 0; i < FS; i++) begin
                  for (int j = 0; j < FS - 1; j++) begin
                     win_d[k][i][j] = win_q[k][i][j+1];
                  end
                  win_d[k][i][FS-1] = tap[i][k*DW +: DW];
               end
            end
            if (row_eff >= ROW_EDGE && col_eff >= COL_EDGE) begin
               wv_d   = 1'b1;
               wrow_d = row_eff - ROW_HALF;
               wcol_d = col_eff - COL_HALF;
               fd_d   = row_last && col_last;
            end
            if (col_last) begin
               col_d  = '0;
               row_d  = row_last ? '0 : row_eff + ROW_ONE;
               wsel_d = {wsel_q[NLB-2:0], wsel_q[NLB-1]};
            end else begin
               col_d = col_eff + COL_ONE;
               row_d = row_eff;
            end
         end
      end
   end

   // Control, counters, window and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_q  <= '0;
         col_q  <= '0;
         lw_q   <= '0;
         fh_q   <= '0;
         err_q  <= 1'b0;
         wsel_q <= NLB'(1);
         win_q  <= '0;
         wv_q   <= 1'b0;
         wrow_q <= '0;
         wcol_q <= '0;
         fd_q   <= 1'b0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         lw_q   <= lw_d;
         fh_q   <= fh_d;
         err_q  <= err_d;
         wsel_q <= wsel_d;
         win_q  <= win_d;
         wv_q   <= wv_d;
         wrow_q <= wrow_d;
         wcol_q <= wcol_d;
         fd_q   <= fd_d;
      end
   end

   // Line RAM write into the currently selected buffer; contents survive reset.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NLB; b++) begin
         if (wr_en && wsel_q[b]) begin
            lbuf_q[b][addr] <= d_in_i;
         end
      end
   end

   assign win_valid_o   = wv_q;
   assign window_data_o = win_q;
   assign win_row_o     = wrow_q;
   assign win_col_o     = wcol_q;
   assign cfa_phase_o   = {wrow_q[0], wcol_q[0]};
   assign frame_done_o  = fd_q;
   assign cfg_err_o     = err_q;

endmodule
